// File: rtl/accumulator_bank.sv
// accumulator_bank
//   Double-buffered accumulator store for the systolic array output path.
//   The fill bank takes accumulate/overwrite requests through a two-stage
//   read-modify-write pipeline with same-address forwarding. The drain bank
//   serves reads with optional read-and-clear. A swap exchanges the two
//   banks once the write pipeline has drained.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_ready      write handshake (wr_ready low while a swap is pending)
//   wr_acc              1 = add wr_data to stored value, 0 = overwrite
//   wr_addr, wr_data    fill-bank address, packed per-column operands
//   rd_en, rd_clr       drain read request, zero the entry after reading
//   rd_addr             drain-bank address
//   rd_data, rd_valid   read result, registered one cycle after rd_en
//   swap_req/swap_done  swap request pulse / swap taken effect pulse
//   fill_sel            current fill bank (drain bank is !fill_sel)
//   ovf                 sticky column overflow flag, cleared by a swap
module accumulator_bank #(
  parameter int NUM_COLS = 2,
  parameter int ACC_W    = 32,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  output logic                      wr_ready,
  input  logic                      wr_acc,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [NUM_COLS*ACC_W-1:0] wr_data,
  input  logic                      rd_en,
  input  logic                      rd_clr,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [NUM_COLS*ACC_W-1:0] rd_data,
  output logic                      rd_valid,
  input  logic                      swap_req,
  output logic                      swap_done,
  output logic                      fill_sel,
  output logic                      ovf
);

  localparam int DATA_W = NUM_COLS * ACC_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Storage banks
  logic [DATA_W-1:0] mem0_r [0:DEPTH-1];
  logic [DATA_W-1:0] mem1_r [0:DEPTH-1];

  // Swap control and outputs
  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              toggle_s;
  logic              fill_sel_r;
  logic              wr_ready_r;
  logic              swap_done_r;
  logic              ovf_r;
  logic              rd_valid_r;
  logic [DATA_W-1:0] rd_data_r;

  // Write pipeline stage 1
  logic              s1_vld_r;
  logic              s1_acc_r;
  logic [ADDR_W-1:0] s1_addr_r;
  logic [DATA_W-1:0] s1_data_r;
  logic [DATA_W-1:0] s1_old_r;

  // Pending drain clear
  logic              clr_vld_r;
  logic              clr_bank_r;
  logic [ADDR_W-1:0] clr_addr_r;

  logic                wr_in_range_s;
  logic                rd_in_range_s;
  logic                wr_accept_s;
  logic                s1_hit_s;
  logic                clr_fill_hit_s;
  logic                clr_drain_hit_s;
  logic [DATA_W-1:0]   fill_ram_s;
  logic [DATA_W-1:0]   drain_ram_s;
  logic [DATA_W-1:0]   fill_old_s;
  logic [DATA_W-1:0]   drain_q_s;
  logic [DATA_W-1:0]   res_s;
  logic [NUM_COLS-1:0] col_ovf_s;
  logic                res_ovf_s;

  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_accept_s   = wr_en && wr_ready_r && wr_in_range_s;

  assign fill_ram_s  = fill_sel_r ? mem1_r[wr_addr] : mem0_r[wr_addr];
  assign drain_ram_s = fill_sel_r ? mem0_r[rd_addr] : mem1_r[rd_addr];

  // A request landing on S1's address must see S1's result, not stale RAM.
  // A clear retiring into the fill bank (only possible right after a swap)
  // likewise has to be seen by a fill read of the same entry.
  assign s1_hit_s        = s1_vld_r && (s1_addr_r == wr_addr);
  assign clr_fill_hit_s  = clr_vld_r && (clr_bank_r == fill_sel_r) && (clr_addr_r == wr_addr);
  assign clr_drain_hit_s = clr_vld_r && (clr_bank_r == !fill_sel_r) && (clr_addr_r == rd_addr);

  // Old-value selection for the fill-side read
  always_comb begin
    fill_old_s = fill_ram_s;
    if (s1_hit_s) begin
      fill_old_s = res_s;
    end else if (clr_fill_hit_s) begin
      fill_old_s = '0;
    end else begin
      fill_old_s = fill_ram_s;
    end
  end

  // Drain read data, with a clear still in flight reading back as zero
  always_comb begin
    drain_q_s = drain_ram_s;
    if (clr_drain_hit_s) begin
      drain_q_s = '0;
    end else begin
      drain_q_s = drain_ram_s;
    end
  end

  // Per-column signed add with optional clamp to the ACC_W signed range
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [ACC_W-1:0] old_s;
    logic [ACC_W-1:0] dat_s;
    logic [ACC_W-1:0] sat_s;
    logic [ACC_W:0]   sum_s;
    logic             ovf_s;

    assign old_s = s1_old_r[c*ACC_W +: ACC_W];
    assign dat_s = s1_data_r[c*ACC_W +: ACC_W];
    assign sum_s = {old_s[ACC_W-1], old_s} + {dat_s[ACC_W-1], dat_s};
    // Overflow when the extended sign disagrees with the ACC_W sign bit
    assign ovf_s = s1_acc_r && (sum_s[ACC_W] != sum_s[ACC_W-1]);
    // The extended sign bit gives the true sign, so it picks the rail
    assign sat_s = sum_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    assign col_ovf_s[c] = ovf_s;
    assign res_s[c*ACC_W +: ACC_W] = !s1_acc_r ? dat_s :
                                     ((ovf_s && (SATURATE != 0)) ? sat_s : sum_s[ACC_W-1:0]);
  end

  assign res_ovf_s = s1_vld_r && (|col_ovf_s);

  // Swap FSM next state; the toggle waits for S1 to retire
  always_comb begin
    state_nxt_s = state_r;
    toggle_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (swap_req) begin
          state_nxt_s = ST_PEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!s1_vld_r) begin
          state_nxt_s = ST_DONE;
          toggle_s    = 1'b1;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Swap state, bank select, handshake outputs and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      fill_sel_r  <= 1'b0;
      wr_ready_r  <= 1'b1;
      swap_done_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      fill_sel_r  <= fill_sel_r ^ toggle_s;
      wr_ready_r  <= (state_nxt_s != ST_PEND);
      swap_done_r <= (state_nxt_s == ST_DONE);
      ovf_r       <= (ovf_r && !toggle_s) || res_ovf_s;
    end
  end

  // Valid bits of the write pipeline and of the pending clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r  <= 1'b0;
      clr_vld_r <= 1'b0;
    end else begin
      s1_vld_r  <= wr_accept_s;
      clr_vld_r <= rd_en && rd_clr && rd_in_range_s;
    end
  end

  // Payload of S1 and of the pending clear (qualified by their valid bits)
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      s1_addr_r <= wr_addr;
      s1_data_r <= wr_data;
      s1_acc_r  <= wr_acc;
      s1_old_r  <= fill_old_s;
    end
    if (rd_en) begin
      clr_addr_r <= rd_addr;
      // Remember the bank read now so a clear retiring after a swap
      // still hits the bank the data came from
      clr_bank_r <= !fill_sel_r;
    end
  end

  // Bank 0 write port: fill retire or drain clear, never both at once
  always_ff @(posedge clk) begin
    if (s1_vld_r && !fill_sel_r) begin
      mem0_r[s1_addr_r] <= res_s;
    end else if (clr_vld_r && !clr_bank_r) begin
      mem0_r[clr_addr_r] <= '0;
    end
  end

  // Bank 1 write port: fill retire or drain clear, never both at once
  always_ff @(posedge clk) begin
    if (s1_vld_r && fill_sel_r) begin
      mem1_r[s1_addr_r] <= res_s;
    end else if (clr_vld_r && clr_bank_r) begin
      mem1_r[clr_addr_r] <= '0;
    end
  end

  // Drain read register; data holds while no read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= drain_q_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign wr_ready  = wr_ready_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign swap_done = swap_done_r;
  assign fill_sel  = fill_sel_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank
//   Two instances (saturating and wrapping, ACC_W=8, DEPTH=16) share all
//   inputs. Each read pushes the expected data of both instances onto a
//   queue; a negedge monitor pops and compares whenever rd_valid is seen.
module tb_accumulator_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_acc = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [15:0] wr_data = 16'd0;
  logic        rd_en = 1'b0;
  logic        rd_clr = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic        swap_req = 1'b0;

  logic        wr_ready_a, rd_valid_a, swap_done_a, fill_sel_a, ovf_a;
  logic        wr_ready_b, rd_valid_b, swap_done_b, fill_sel_b, ovf_b;
  logic [15:0] rd_data_a, rd_data_b;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_e;
  logic        exp_rv;
  logic        exp_fill = 1'b0;
  logic [15:0] last_a = 16'd0;

  accumulator_bank #(.NUM_COLS(2), .ACC_W(8), .DEPTH(16), .ADDR_W(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ready(wr_ready_a), .wr_acc(wr_acc),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_clr(rd_clr), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .swap_req(swap_req), .swap_done(swap_done_a),
    .fill_sel(fill_sel_a), .ovf(ovf_a)
  );

  accumulator_bank #(.NUM_COLS(2), .ACC_W(8), .DEPTH(16), .ADDR_W(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ready(wr_ready_b), .wr_acc(wr_acc),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_clr(rd_clr), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .swap_req(swap_req), .swap_done(swap_done_b),
    .fill_sel(fill_sel_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(input int c0, input int c1);
    return {8'(c1), 8'(c0)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [3:0] a, input logic acc, input int c0, input int c1);
    wr_en   = 1'b1;
    wr_acc  = acc;
    wr_addr = a;
    wr_data = pk(c0, c1);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic clr, input logic [15:0] ea, input logic [15:0] eb);
    rd_en   = 1'b1;
    rd_clr  = clr;
    rd_addr = a;
    exp_q.push_back({ea, eb});
    last_a = ea;
    cyc();
    rd_en  = 1'b0;
    rd_clr = 1'b0;
  endtask

  task automatic do_swap();
    int n;
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    check_eq("wr_ready_pend", 32'(wr_ready_a), 32'd0);
    n = 0;
    while (!swap_done_a && n < 8) begin
      cyc();
      n++;
    end
    check_eq("swap_done_seen", 32'(swap_done_a), 32'd1);
    exp_fill = !exp_fill;
    check_eq("fill_sel", 32'(fill_sel_a), 32'(exp_fill));
    check_eq("wr_ready_done", 32'(wr_ready_a), 32'd1);
    check_eq("ovf_after_swap", 32'({ovf_a, ovf_b}), 32'd0);
    cyc();
    check_eq("swap_done_pulse", 32'(swap_done_a), 32'd0);
  endtask

  // Expected rd_valid: registered copy of rd_en, cleared by reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_rv <= 1'b0;
    else        exp_rv <= rd_en;
  end

  // Scoreboard monitor, sampling away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("rd_valid_sat", 32'(rd_valid_a), 32'(exp_rv));
      check_eq("rd_valid_wrap", 32'(rd_valid_b), 32'(exp_rv));
      if (rd_valid_a) begin
        check_eq("rd_expected_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check_eq("rd_data_sat", 32'(rd_data_a), 32'(exp_e[31:16]));
          check_eq("rd_data_wrap", 32'(rd_data_b), 32'(exp_e[15:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rd_data", 32'(rd_data_a), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid_a), 32'd0);
    check_eq("rst_wr_ready", 32'({wr_ready_a, wr_ready_b}), 32'd3);
    check_eq("rst_swap_done", 32'({swap_done_a, swap_done_b}), 32'd0);
    check_eq("rst_fill_sel", 32'({fill_sel_a, fill_sel_b}), 32'd0);
    check_eq("rst_ovf", 32'({ovf_a, ovf_b}), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Fill bank 0: overwrite+accumulate, forwarding, 2-apart accumulates
    wr(4'd5, 1'b0, 10, -3);
    wr(4'd5, 1'b1, 7, 4);
    wr(4'd9, 1'b0, 0, 0);
    repeat (4) wr(4'd9, 1'b1, 1, 1);
    wr(4'd11, 1'b0, 0, 0);
    wr(4'd12, 1'b0, 0, 0);
    repeat (2) begin
      wr(4'd11, 1'b1, 1, 1);
      wr(4'd12, 1'b1, 1, 1);
    end
    wr(4'd3, 1'b0, 5, 6);
    idle(1);
    check_eq("ovf_quiet", 32'({ovf_a, ovf_b}), 32'd0);
    // Positive overflow, then negative overflow in both columns
    wr(4'd7, 1'b0, 120, 0);
    wr(4'd7, 1'b1, 20, 0);
    idle(1);
    check_eq("ovf_sat", 32'(ovf_a), 32'd1);
    check_eq("ovf_wrap", 32'(ovf_b), 32'd1);
    wr(4'd8, 1'b0, -100, -128);
    wr(4'd8, 1'b1, -100, -1);
    idle(1);

    // Swap with a write accepted in the request cycle; write during PEND ignored
    wr_en = 1'b1; wr_acc = 1'b0; wr_addr = 4'd6; wr_data = pk(33, 44);
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    wr_addr = 4'd5; wr_data = pk(99, 99);
    check_eq("hs_wr_ready_low", 32'(wr_ready_a), 32'd0);
    check_eq("hs_fill_hold0", 32'(fill_sel_a), 32'd0);
    cyc();
    check_eq("hs_fill_hold1", 32'(fill_sel_a), 32'd0);
    check_eq("hs_done_early", 32'(swap_done_a), 32'd0);
    check_eq("hs_wr_ready_low2", 32'(wr_ready_a), 32'd0);
    cyc();
    wr_en = 1'b0;
    exp_fill = 1'b1;
    check_eq("hs_fill_toggle", 32'(fill_sel_a), 32'd1);
    check_eq("hs_done", 32'(swap_done_a), 32'd1);
    check_eq("hs_wr_ready_back", 32'(wr_ready_a), 32'd1);
    check_eq("hs_ovf_cleared", 32'({ovf_a, ovf_b}), 32'd0);
    cyc();
    check_eq("hs_done_pulse", 32'(swap_done_a), 32'd0);

    // Drain bank 0
    rd(4'd5, 1'b0, pk(17, 1), pk(17, 1));
    rd(4'd9, 1'b0, pk(4, 4), pk(4, 4));
    rd(4'd11, 1'b0, pk(2, 2), pk(2, 2));
    rd(4'd12, 1'b0, pk(2, 2), pk(2, 2));
    rd(4'd7, 1'b0, pk(127, 0), pk(-116, 0));
    rd(4'd8, 1'b0, pk(-128, -128), pk(56, 127));
    rd(4'd6, 1'b0, pk(33, 44), pk(33, 44));
    idle(2);
    check_eq("rd_hold", 32'(rd_data_a), 32'(last_a));
    rd(4'd3, 1'b1, pk(5, 6), pk(5, 6));
    rd(4'd3, 1'b0, pk(0, 0), pk(0, 0));
    // Fill bank 1 with alternating-address accumulates
    wr(4'd9, 1'b0, 0, 0);
    wr(4'd10, 1'b0, 0, 0);
    repeat (2) begin
      wr(4'd9, 1'b1, 1, 1);
      wr(4'd10, 1'b1, 1, 1);
    end
    rd(4'd3, 1'b0, pk(0, 0), pk(0, 0));
    idle(1);

    do_swap();
    rd(4'd9, 1'b0, pk(2, 2), pk(2, 2));
    rd(4'd10, 1'b0, pk(2, 2), pk(2, 2));
    wr(4'd3, 1'b1, 2, 2);
    idle(1);

    // Read-and-clear issued on the toggle edge, then accumulate into the same entry
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    check_eq("sw3_wr_ready_low", 32'(wr_ready_a), 32'd0);
    rd_en = 1'b1; rd_clr = 1'b1; rd_addr = 4'd10;
    exp_q.push_back({pk(2, 2), pk(2, 2)});
    cyc();
    rd_en = 1'b0; rd_clr = 1'b0;
    exp_fill = 1'b1;
    check_eq("sw3_done", 32'(swap_done_a), 32'd1);
    check_eq("sw3_fill", 32'(fill_sel_a), 32'd1);
    wr(4'd10, 1'b1, 3, 3);
    check_eq("sw3_done_pulse", 32'(swap_done_a), 32'd0);
    rd(4'd3, 1'b0, pk(2, 2), pk(2, 2));
    rd(4'd5, 1'b0, pk(17, 1), pk(17, 1));
    idle(1);

    do_swap();
    rd(4'd10, 1'b0, pk(3, 3), pk(3, 3));
    idle(1);
    do_swap();

    // Async reset during an in-flight accumulate
    wr_en = 1'b1; wr_acc = 1'b1; wr_addr = 4'd10; wr_data = pk(1, 1);
    rd_en = 1'b1; rd_clr = 1'b0; rd_addr = 4'd5;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("pre_rst_valid", 32'(rd_valid_a), 32'd1);
    check_eq("pre_rst_data", 32'(rd_data_a), 32'(pk(17, 1)));
    check_eq("pre_rst_fill", 32'(fill_sel_a), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_fill = 1'b0;
    check_eq("mid_rst_rd_data", 32'(rd_data_a), 32'd0);
    check_eq("mid_rst_rd_valid", 32'(rd_valid_a), 32'd0);
    check_eq("mid_rst_fill", 32'({fill_sel_a, fill_sel_b}), 32'd0);
    check_eq("mid_rst_wr_ready", 32'(wr_ready_a), 32'd1);
    check_eq("mid_rst_swap_done", 32'(swap_done_a), 32'd0);
    check_eq("mid_rst_ovf", 32'({ovf_a, ovf_b}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    check_eq("post_rst_wr_ready", 32'(wr_ready_a), 32'd1);
    rd(4'd10, 1'b0, pk(3, 3), pk(3, 3));
    idle(2);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accumulator_bank.md
Name: accumulator_bank

Overview:
- Parametrised, double-buffered accumulator memory for the systolic array output path. Generalises the fixed 2-column, 256-entry, 64-bit store.
- Per-column signed accumulate (read-modify-write) or overwrite into a fill bank, pipelined with same-address forwarding.
- Drain-side reads come from the opposite bank, with optional read-and-clear.
- Bank swap uses a req/done handshake and completes only once the write pipeline has drained.

Parameters:
- NUM_COLS, 2, number of accumulator columns packed per entry (column 0 in the LSBs).
- ACC_W, 32, signed width of each column accumulator.
- DEPTH, 256, entries per bank.
- ADDR_W, $clog2(DEPTH), address width.
- SATURATE, 0, 1 = clamp column sums to signed ACC_W range; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request; accepted when wr_en && wr_ready
- wr_ready  out  1  low while a swap is pending
- wr_acc  in  1  1 = add wr_data to the stored value; 0 = overwrite
- wr_addr  in  ADDR_W  fill-bank address
- wr_data  in  NUM_COLS*ACC_W  per-column operands
- rd_en  in  1  drain-bank read request (always accepted)
- rd_clr  in  1  with rd_en: zero the entry after reading it
- rd_addr  in  ADDR_W  drain-bank address
- rd_data  out  NUM_COLS*ACC_W  read data
- rd_valid  out  1  rd_data valid
- swap_req  in  1  single-cycle pulse requesting a bank swap
- swap_done  out  1  one-cycle pulse when the swap has taken effect
- fill_sel  out  1  current fill bank; the drain bank is !fill_sel
- ovf  out  1  sticky: some column saturated or wrapped since the last swap

Behaviour:
- Reset values: rd_data=0, rd_valid=0, wr_ready=1, swap_done=0, fill_sel=0, ovf=0. Pipeline valid and swap_pending are cleared. RAM contents are not reset.
- Reset mid-operation: the in-flight stage-1 write is discarded. A pending swap is cancelled.
- Storage: two banks of DEPTH x NUM_COLS*ACC_W. Each bank has one synchronous read port and one write port. The write pipeline addresses the fill bank; the drain port addresses the other bank.
- Write pipeline:
  - Edge k: an accepted request is captured into S1 (addr, data, acc) and the fill bank is read synchronously.
  - Edge k+1: per column, result = acc ? old+data : data, written to the fill bank.
  - Address out of range (>= DEPTH): request dropped.
- Forwarding: if the request captured at edge k+1 has the same address as S1, its old value is S1's result, not RAM data. Back-to-back accumulates to one address at full rate must therefore be exact.
- Arithmetic: per column, signed, ACC_W bits.
  - SATURATE=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SATURATE=0: wrap.
  - Either way, overflow sets ovf. ovf clears on the swap edge unless the same edge also overflows.
- Drain read:
  - rd_en at edge k: rd_data = drain[rd_addr] and rd_valid=1 after edge k. rd_valid is low the cycle after any cycle with rd_en=0. rd_data holds its value when rd_en=0.
  - rd_clr: drain[rd_addr] <= 0 at edge k+1. A read of the same address at edge k+1 returns 0.
- Swap FSM:
  - IDLE: swap_req -> PEND, with wr_ready=0 from the next cycle. A write accepted in the same cycle as swap_req is still performed.
  - PEND: when S1 is empty, toggle fill_sel at that edge -> DONE.
  - DONE: swap_done=1 for exactly one cycle, wr_ready=1 -> IDLE.
  - swap_req while in PEND or DONE is ignored.
- Reads during a swap: a read sampled on the toggle edge uses the pre-toggle drain bank.
- Simultaneous events: fill and drain writes go to different banks and never conflict. An rd_clr write retiring on the toggle edge still targets the bank that was the drain bank when the read was issued.

Test Plan:
- Overwrite then accumulate: wr(addr 5, acc=0, cols {10,-3}), then wr(addr 5, acc=1, {7,4}), then swap, then rd addr 5 -> rd_data cols {17,1}, rd_valid one cycle after rd_en.
- Forwarding: four consecutive accumulate writes of {1,1} to addr 9 after an overwrite of {0,0}, then swap and read -> {4,4}. Repeat with alternating addresses 9/10 -> {2,2} each.
- Saturation: SATURATE=1, ACC_W=8, write 120 then accumulate 20 -> 127 with ovf=1. SATURATE=0 -> -116 with ovf=1. After the next swap, ovf=0.
- Swap handshake: swap_req pulsed while S1 is valid -> wr_ready low next cycle. fill_sel toggles only after S1 is empty. swap_done is high for exactly one cycle. wr_en issued while wr_ready=0 leaves memory unchanged.
- Read-and-clear: drain addr 3 holds {5,6}. rd_en+rd_clr at cycle k -> {5,6}. rd_en at cycle k+1 -> {0,0}. After two swaps, accumulating {2,2} into addr 3 -> {2,2}.
- Async reset asserted mid-accumulate: all outputs go to their reset values immediately, fill_sel=0, and after release wr_ready=1 with no stray write performed.
